// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external, pipelined ALU between two requesters.
// One operation is in flight at most. Requests are arbitrated round-robin
// on ties, and the result is returned on the winning requester's response port.
//
// Handshake semantics (both request and response sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A requester keeps valid and its payload stable until it sees ready.
//   ready never depends on the payload, only on state and valid.
//   On the response side, rsp_data is stable while rspN_valid is high.
//   rspN_ready is ignored whenever rspN_valid is low.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_s,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_s,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_out,

  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The counter only ever holds values 0 .. ALU_LAT-1.
  localparam int             CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(ALU_LAT - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          pick;
  logic          accept;
  logic          rsp_take;
  logic          cnt_zero;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last_grant;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  // An accept is only possible out of reset, in IDLE. Gating with rst keeps
  // ready low while reset is held, even though state already reads IDLE.
  assign accept     = rst && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !pick;
  assign req1_ready = accept && pick;

  // Only the owner of the in-flight operation sees a response.
  assign rsp0_valid = (state == RESP) && !grant;
  assign rsp1_valid = (state == RESP) && grant;
  assign rsp_take   = grant ? rsp1_ready : rsp0_ready;

  assign busy       = (state != IDLE);
  assign cnt_zero   = (cnt == '0);

  // Next-state logic for the four-state operation sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = ISSUE;
      ISSUE:                 state_next = WAIT;
      WAIT:    if (cnt_zero) state_next = RESP;
      RESP:    if (rsp_take) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latency counter: loaded leaving ISSUE, counts down in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && !cnt_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  // ALU operands, select and ownership change only on an accepting edge.
  // The select code is passed through untouched; decoding is the ALU's job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_a      <= pick ? req1_a : req0_a;
      alu_b      <= pick ? req1_b : req0_b;
      alu_s      <= pick ? req1_s : req0_s;
      grant      <= pick;
      last_grant <= pick;
    end
  end

  // Result capture on the last WAIT edge; held through RESP backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
    end else if ((state == WAIT) && cnt_zero) begin
      rsp_data <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with ALU_LAT=1 (instance a)
// and ALU_LAT=3 (instance b), each driving a small pipelined ALU model.
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // ---------------- instance a: ALU_LAT = 1 ----------------
  logic        a_r0v, a_r0rdy, a_r1v, a_r1rdy;
  logic [31:0] a_r0a, a_r0b, a_r1a, a_r1b;
  logic [2:0]  a_r0s, a_r1s;
  logic        a_p0v, a_p0r, a_p1v, a_p1r;
  logic [31:0] a_rsp_data, a_alu_a, a_alu_b, a_alu_out;
  logic [2:0]  a_alu_s;
  logic        a_busy, a_grant;

  alu_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_r0v), .req0_ready(a_r0rdy), .req0_a(a_r0a), .req0_b(a_r0b), .req0_s(a_r0s),
    .req1_valid(a_r1v), .req1_ready(a_r1rdy), .req1_a(a_r1a), .req1_b(a_r1b), .req1_s(a_r1s),
    .rsp0_valid(a_p0v), .rsp0_ready(a_p0r), .rsp1_valid(a_p1v), .rsp1_ready(a_p1r),
    .rsp_data(a_rsp_data), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_s(a_alu_s),
    .alu_out(a_alu_out), .busy(a_busy), .grant(a_grant)
  );

  // ---------------- instance b: ALU_LAT = 3 ----------------
  logic        b_r0v, b_r0rdy, b_r1v, b_r1rdy;
  logic [31:0] b_r0a, b_r0b, b_r1a, b_r1b;
  logic [2:0]  b_r0s, b_r1s;
  logic        b_p0v, b_p0r, b_p1v, b_p1r;
  logic [31:0] b_rsp_data, b_alu_a, b_alu_b, b_alu_out;
  logic [2:0]  b_alu_s;
  logic        b_busy, b_grant;

  alu_arbiter #(.WIDTH(32), .ALU_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_a(b_r0a), .req0_b(b_r0b), .req0_s(b_r0s),
    .req1_valid(b_r1v), .req1_ready(b_r1rdy), .req1_a(b_r1a), .req1_b(b_r1b), .req1_s(b_r1s),
    .rsp0_valid(b_p0v), .rsp0_ready(b_p0r), .rsp1_valid(b_p1v), .rsp1_ready(b_p1r),
    .rsp_data(b_rsp_data), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_s(b_alu_s),
    .alu_out(b_alu_out), .busy(b_busy), .grant(b_grant)
  );

  // ---------------- ALU models ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] s);
    case (s)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = a << b[4:0];
      3'd6:    alu_f = a >> b[4:0];
      default: alu_f = ~a;
    endcase
  endfunction

  logic [31:0] b_pipe1, b_pipe2;
  always @(posedge clk) a_alu_out <= alu_f(a_alu_a, a_alu_b, a_alu_s);
  always @(posedge clk) begin
    b_pipe1   <= alu_f(b_alu_a, b_alu_b, b_alu_s);
    b_pipe2   <= b_pipe1;
    b_alu_out <= b_pipe2;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation on instance a with the response taken at once.
  // Edge count includes the accepting edge: response visible after edge 3.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s, input logic [31:0] exp, input string tag);
    if (idx == 0) begin
      a_r0a = a; a_r0b = b; a_r0s = s; a_r0v = 1'b1;
    end else begin
      a_r1a = a; a_r1b = b; a_r1s = s; a_r1v = 1'b1;
    end
    #1;
    check({tag, "_ready0"}, a_r0rdy, idx == 0);
    check({tag, "_ready1"}, a_r1rdy, idx == 1);
    step();
    a_r0v = 1'b0;
    a_r1v = 1'b0;
    check({tag, "_alu_a"}, a_alu_a, a);
    check({tag, "_alu_b"}, a_alu_b, b);
    check({tag, "_alu_s"}, a_alu_s, s);
    check({tag, "_grant"}, a_grant, idx);
    check({tag, "_ready_after"}, a_r0rdy | a_r1rdy, 0);
    step();
    check({tag, "_early_rsp"}, a_p0v | a_p1v, 0);
    step();
    check({tag, "_rsp0_valid"}, a_p0v, idx == 0);
    check({tag, "_rsp1_valid"}, a_p1v, idx == 1);
    check({tag, "_rsp_data"}, a_rsp_data, exp);
    step();
    check({tag, "_idle"}, a_busy, 0);
  endtask

  logic [31:0] sweep_exp [8];

  // ---------------- directed sequence ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    a_r0v = 0; a_r0a = 0; a_r0b = 0; a_r0s = 0;
    a_r1v = 0; a_r1a = 0; a_r1b = 0; a_r1s = 0;
    a_p0r = 1; a_p1r = 1;
    b_r0v = 0; b_r0a = 0; b_r0b = 0; b_r0s = 0;
    b_r1v = 0; b_r1a = 0; b_r1b = 0; b_r1s = 0;
    b_p0r = 1; b_p1r = 1;

    // Reset held with requests pending: everything stays at reset values.
    a_r0a = 32'd3;    a_r0b = 32'd4; a_r0s = 3'd0;
    a_r1a = 32'h10;   a_r1b = 32'd3; a_r1s = 3'd1;
    a_r0v = 1'b1;     a_r1v = 1'b1;
    step();
    step();
    check("rst_ready0", a_r0rdy, 0);
    check("rst_ready1", a_r1rdy, 0);
    check("rst_busy", a_busy, 0);
    check("rst_grant", a_grant, 0);
    check("rst_alu_a", a_alu_a, 0);
    check("rst_alu_b", a_alu_b, 0);
    check("rst_alu_s", a_alu_s, 0);
    check("rst_rsp_data", a_rsp_data, 0);
    check("rst_rsp_valid", a_p0v | a_p1v, 0);

    // Tie from reset release: grants alternate 0,1,0,1.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tie_ready0", a_r0rdy, (i % 2) == 0);
      check("tie_ready1", a_r1rdy, (i % 2) == 1);
      step();
      check("tie_grant", a_grant, i % 2);
      check("tie_alu_a", a_alu_a, ((i % 2) == 1) ? 32'h10 : 32'd3);
      step();
      check("tie_early_rsp", a_p0v | a_p1v, 0);
      step();
      check("tie_rsp0_valid", a_p0v, (i % 2) == 0);
      check("tie_rsp1_valid", a_p1v, (i % 2) == 1);
      check("tie_rsp_data", a_rsp_data, ((i % 2) == 1) ? 32'hD : 32'h7);
      step();
      check("tie_idle", a_busy, 0);
    end
    a_r0v = 1'b0;
    a_r1v = 1'b0;

    // Single operation on requester 0.
    run_op(0, 32'h5F, 32'h0A, 3'd0, 32'h69, "single");
    step();
    step();
    check("hold_alu_a", a_alu_a, 32'h5F);
    check("hold_alu_b", a_alu_b, 32'h0A);

    // Select sweep, all eight codes.
    sweep_exp[0] = 32'h69;     sweep_exp[1] = 32'h55;
    sweep_exp[2] = 32'h0A;     sweep_exp[3] = 32'h5F;
    sweep_exp[4] = 32'h55;     sweep_exp[5] = 32'h17C00;
    sweep_exp[6] = 32'h0;      sweep_exp[7] = 32'hFFFFFFA0;
    for (int s = 0; s < 8; s++) begin
      run_op(s % 2, 32'h5F, 32'h0A, 3'(s), sweep_exp[s], "sweep");
    end

    // Backpressure on requester 1, with requester 0 waiting meanwhile.
    a_p1r = 1'b0;
    a_r1a = 32'h20; a_r1b = 32'h22; a_r1s = 3'd0; a_r1v = 1'b1;
    #1;
    check("bp_ready1", a_r1rdy, 1);
    step();
    a_r1v = 1'b0;
    a_r0a = 32'd1; a_r0b = 32'd2; a_r0s = 3'd0; a_r0v = 1'b1;
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp1_valid", a_p1v, 1);
      check("bp_rsp_data", a_rsp_data, 32'h42);
      check("bp_busy", a_busy, 1);
      check("bp_ready0", a_r0rdy, 0);
      step();
    end
    a_p1r = 1'b1;
    step();
    check("bp_release_busy", a_busy, 0);
    check("bp_release_rsp1", a_p1v, 0);
    check("bp_held_req_ready", a_r0rdy, 1);
    step();
    a_r0v = 1'b0;
    check("bp_held_grant", a_grant, 0);
    step();
    step();
    check("bp_held_rsp0", a_p0v, 1);
    check("bp_held_data", a_rsp_data, 32'h3);
    step();

    // Reset during WAIT discards the operation.
    a_r0a = 32'd7; a_r0b = 32'd8; a_r0s = 3'd0; a_r0v = 1'b1;
    #1;
    check("mid_ready0", a_r0rdy, 1);
    step();
    a_r0v = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("mid_busy", a_busy, 0);
    check("mid_alu_a", a_alu_a, 0);
    check("mid_alu_b", a_alu_b, 0);
    check("mid_rsp_data", a_rsp_data, 0);
    check("mid_rsp_valid", a_p0v | a_p1v, 0);
    a_r0a = 32'd2;  a_r0b = 32'd3; a_r0s = 3'd0; a_r0v = 1'b1;
    a_r1a = 32'h30; a_r1b = 32'd1; a_r1s = 3'd0; a_r1v = 1'b1;
    #1;
    check("mid_ready_in_rst", a_r0rdy | a_r1rdy, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("post_ready0", a_r0rdy, 1);
    check("post_ready1", a_r1rdy, 0);
    check("post_no_rsp", a_p0v | a_p1v, 0);
    step();
    a_r0v = 1'b0;
    a_r1v = 1'b0;
    check("post_grant", a_grant, 0);
    check("post_alu_a", a_alu_a, 32'd2);
    step();
    check("post_early_rsp", a_p0v | a_p1v, 0);
    step();
    check("post_rsp0", a_p0v, 1);
    check("post_data", a_rsp_data, 32'd5);
    step();

    // Latency sweep on the ALU_LAT=3 instance: response after edge 5,
    // counting the accepting edge.
    b_r0a = 32'h5F; b_r0b = 32'h0A; b_r0s = 3'd4; b_r0v = 1'b1;
    #1;
    check("lat3_ready0", b_r0rdy, 1);
    step();
    b_r0v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("lat3_early_rsp", b_p0v | b_p1v, 0);
      check("lat3_alu_a", b_alu_a, 32'h5F);
      check("lat3_alu_s", b_alu_s, 3'd4);
      check("lat3_busy", b_busy, 1);
    end
    step();
    check("lat3_rsp0", b_p0v, 1);
    check("lat3_rsp1", b_p1v, 0);
    check("lat3_data", b_rsp_data, 32'h55);
    step();
    check("lat3_idle", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
